// File: rtl/prewish_debounce_multi_pkg.sv
// Shared defaults and helpers for the multi-channel prewish debouncer.
// Channel decision encoding and counter sizing live here so top and channel agree.
package prewish_debounce_multi_pkg;

  localparam int unsigned PREWISH_NUM_BTNS   = 8;
  localparam int unsigned PREWISH_DB_SAMPLES = 4;
  localparam int unsigned PREWISH_ALIVE_BITS = 4;
  localparam int unsigned PREWISH_BUS_W      = 8;

  typedef enum logic [1:0] {
    CH_HOLD   = 2'd0,
    CH_AGREE  = 2'd1,
    CH_COUNT  = 2'd2,
    CH_COMMIT = 2'd3
  } chan_act_e;

  function automatic int unsigned cnt_width(input int unsigned samples);
    return (samples <= 1) ? 1 : $clog2(samples);
  endfunction

endpackage

// File: rtl/prewish_debounce_multi_chan.sv
// One debounce channel: 2-flop pad synchroniser, disagreement counter,
// debounced state and a combinational commit pulse valid during the tick cycle.
module prewish_debounce_chan
  import prewish_debounce_multi_pkg::*;
#(
  parameter int unsigned DB_SAMPLES = PREWISH_DB_SAMPLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pad_ni,
  input  logic tick_i,
  output logic state_o,
  output logic commit_o
);

  localparam int unsigned CW = cnt_width(DB_SAMPLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_SAMPLES - 1);

  logic          sync1_q, sync2_q;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          raw;
  chan_act_e     act;

  assign raw = ~sync2_q;

  always_comb begin
    act = CH_HOLD;
    if (tick_i) begin
      if (raw == state_q)        act = CH_AGREE;
      else if (cnt_q == CNT_LAST) act = CH_COMMIT;
      else                        act = CH_COUNT;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (act)
      CH_HOLD:   ;
      CH_AGREE:  cnt_d = '0;
      CH_COUNT:  cnt_d = cnt_q + 1'b1;
      CH_COMMIT: begin
        state_d = raw;
        cnt_d   = '0;
      end
    endcase
  end

  // Sync flops reset to the released pad level so reset itself never looks like a press.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pad_ni;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o  = state_q;
  assign commit_o = (act == CH_COMMIT);

endmodule

// File: rtl/prewish_debounce_multi.sv
// N-channel button debouncer: dbclock tick detection, per-channel debounce,
// mask register, change-event aggregation and heartbeat.
module prewish_debounce_multi
  import prewish_debounce_multi_pkg::*;
#(
  parameter int unsigned NUM_BTNS   = PREWISH_NUM_BTNS,
  parameter int unsigned DB_SAMPLES = PREWISH_DB_SAMPLES,
  parameter int unsigned ALIVE_BITS = PREWISH_ALIVE_BITS
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic [NUM_BTNS-1:0]      iN_button,
  input  logic                     i_dbclock,
  input  logic                     STB_I,
  input  logic [PREWISH_BUS_W-1:0] DAT_I,
  output logic                     STB_O,
  output logic [NUM_BTNS-1:0]      DAT_O,
  output logic [NUM_BTNS-1:0]      o_changed,
  output logic                     o_alive
);

  logic                  db_sync1_q, db_sync2_q, db_prev_q;
  logic                  tick;
  logic [NUM_BTNS-1:0]   commit;
  logic [NUM_BTNS-1:0]   mask_q, mask_d;
  logic [NUM_BTNS-1:0]   changed_q, changed_d;
  logic                  stb_q, stb_d;
  logic [ALIVE_BITS-1:0] alive_cnt_q, alive_cnt_d;
  logic                  alive_q, alive_d;
  logic                  unused_dat;

  assign unused_dat = ^DAT_I;
  assign tick       = db_sync2_q & ~db_prev_q;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
    prewish_debounce_chan #(
      .DB_SAMPLES(DB_SAMPLES)
    ) u_chan (
      .clk_i   (CLK_I),
      .rst_ni  (RST_I),
      .pad_ni  (iN_button[g]),
      .tick_i  (tick),
      .state_o (DAT_O[g]),
      .commit_o(commit[g])
    );
  end

  // The event is filtered by the mask currently held, so a same-cycle mask write
  // only takes effect for the following commits.
  always_comb begin
    mask_d      = STB_I ? DAT_I[NUM_BTNS-1:0] : mask_q;
    changed_d   = commit & mask_q;
    stb_d       = |(commit & mask_q);
    alive_cnt_d = alive_cnt_q;
    alive_d     = alive_q;
    if (tick) begin
      alive_cnt_d = alive_cnt_q + 1'b1;
      if (&alive_cnt_q) alive_d = ~alive_q;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      db_sync1_q  <= 1'b0;
      db_sync2_q  <= 1'b0;
      db_prev_q   <= 1'b0;
      mask_q      <= '1;
      changed_q   <= '0;
      stb_q       <= 1'b0;
      alive_cnt_q <= '0;
      alive_q     <= 1'b0;
    end else begin
      db_sync1_q  <= i_dbclock;
      db_sync2_q  <= db_sync1_q;
      db_prev_q   <= db_sync2_q;
      mask_q      <= mask_d;
      changed_q   <= changed_d;
      stb_q       <= stb_d;
      alive_cnt_q <= alive_cnt_d;
      alive_q     <= alive_d;
    end
  end

  assign STB_O     = stb_q;
  assign o_changed = changed_q;
  assign o_alive   = alive_q;

endmodule

// File: tb/tb_prewish_debounce_multi.sv
// Bench for prewish_debounce_multi: directed scenarios plus random pads/mask,
// checked per dbclock tick against a sample-level debounce model.
module tb_prewish_debounce_multi;

  localparam int unsigned NB = 8;
  localparam int unsigned DB = 4;
  localparam int unsigned AB = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       dbclk = 1'b0;
  logic       stb_i = 1'b0;
  logic [7:0] pads  = 8'hFF;
  logic [7:0] dat_i = 8'h00;
  logic       stb_o;
  logic       alive;
  logic [7:0] dat_o;
  logic [7:0] changed;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned seen_events = 0;
  int unsigned exp_events = 0;

  logic [7:0]  m_state;
  logic [7:0]  m_mask;
  int unsigned m_run[NB];
  int unsigned m_ticks;

  prewish_debounce_multi #(
    .NUM_BTNS  (NB),
    .DB_SAMPLES(DB),
    .ALIVE_BITS(AB)
  ) dut (
    .CLK_I    (clk),
    .RST_I    (rst_n),
    .iN_button(pads),
    .i_dbclock(dbclk),
    .STB_I    (stb_i),
    .DAT_I    (dat_i),
    .STB_O    (stb_o),
    .DAT_O    (dat_o),
    .o_changed(changed),
    .o_alive  (alive)
  );

  always #1 clk = ~clk;
  always #128 dbclk = ~dbclk;

  always @(negedge clk) if (stb_o === 1'b1) seen_events++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 8'h00;
    m_mask  = 8'hFF;
    m_ticks = 0;
    foreach (m_run[i]) m_run[i] = 0;
  endtask

  // A channel flips once DB consecutive samples disagree with its debounced level.
  task automatic model_tick(output logic [7:0] commit);
    logic [7:0] pressed;
    pressed = ~pads;
    commit  = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (pressed[i] != m_state[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_state[i] = pressed[i];
          m_run[i]   = 0;
          commit[i]  = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_ticks++;
  endtask

  task automatic check_event(input logic [7:0] ev);
    check("dat_o", dat_o, m_state);
    check("stb_o", stb_o, |ev);
    check("o_changed", changed, ev);
    check("o_alive", alive, (m_ticks >> AB) & 1);
    if (ev != 8'h00) exp_events++;
  endtask

  task automatic check_quiet();
    check("stb_o_clear", stb_o, 0);
    check("o_changed_clear", changed, 0);
  endtask

  task automatic run_tick(input logic [7:0] bounce, input bit do_mask, input logic [7:0] mval);
    logic [7:0] c, ev;
    @(posedge dbclk);
    model_tick(c);
    ev = c & m_mask;
    #4;
    if (do_mask) begin
      stb_i = 1'b1;
      dat_i = mval;
    end
    #2;
    check_event(ev);
    if (do_mask) begin
      stb_i  = 1'b0;
      m_mask = mval;
    end
    #2;
    check_quiet();
    #8;
    for (int k = 0; k < 7; k++) begin
      pads = pads ^ (bounce & 8'($urandom));
      #32;
    end
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) run_tick(8'h00, 1'b0, 8'h00);
  endtask

  task automatic write_mask(input logic [7:0] v);
    stb_i = 1'b1;
    dat_i = v;
    #2;
    stb_i  = 1'b0;
    m_mask = v;
  endtask

  // mode 0: now, 1: at dbclock fall, 2: at dbclock rise (released while dbclock high)
  task automatic do_reset(input int unsigned mode);
    logic [7:0] c;
    if (mode == 1) @(negedge dbclk);
    else if (mode == 2) @(posedge dbclk);
    rst_n = 1'b0;
    model_reset();
    #18;
    check("rst_dat_o", dat_o, 0);
    check("rst_stb_o", stb_o, 0);
    check("rst_o_changed", changed, 0);
    check("rst_o_alive", alive, 0);
    #2;
    rst_n = 1'b1;
    if (mode == 2) begin
      model_tick(c);
      #6;
      check_event(c & m_mask);
      #2;
      check_quiet();
    end
  endtask

  logic [7:0] rb, rm;
  bit         rdm;

  initial begin
    model_reset();
    do_reset(0);

    pads[0] = 1'b0;
    ticks(5);
    pads[0] = 1'b1;
    ticks(5);

    for (int i = 0; i < 3; i++) run_tick(8'h08, 1'b0, 8'h00);
    pads[3] = 1'b0;
    ticks(5);

    pads[5] = 1'b0;
    ticks(3);
    pads[5] = 1'b1;
    ticks(1);
    pads[5] = 1'b0;
    ticks(5);

    pads = pads & ~8'h42;
    ticks(5);

    write_mask(8'hFE);
    pads[0] = 1'b0;
    ticks(5);
    pads[1] = 1'b1;
    ticks(3);
    run_tick(8'h00, 1'b1, 8'h00);
    pads[6] = 1'b1;
    ticks(5);
    write_mask(8'hFF);

    pads[2] = 1'b0;
    ticks(2);
    do_reset(1);
    ticks(5);

    do_reset(2);
    ticks(4);

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(3) == 0) pads = 8'($urandom);
      rb  = ($urandom_range(4) == 0) ? 8'($urandom) : 8'h00;
      rdm = ($urandom_range(7) == 0);
      rm  = 8'($urandom);
      run_tick(rb, rdm, rm);
    end

    #40;
    check("event_count", seen_events, exp_events);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
